// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage: multi-cycle loads/stores against a local
// word-addressed data memory, with a registered MEM/WB output bundle.
module memory_access_stage #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_MemRead,
  input  logic              in_MemWrite,
  input  logic              in_MemtoReg,
  input  logic              in_RegWrite,
  input  logic [2:0]        in_WriteReg,
  input  logic [DATA_W-1:0] in_ALUResult,
  input  logic [DATA_W-1:0] in_StoreData,
  output logic              out_stall,
  output logic              out_valid,
  output logic              out_MemtoReg,
  output logic              out_RegWrite,
  output logic [2:0]        out_WriteReg,
  output logic [DATA_W-1:0] out_ALUResult,
  output logic [DATA_W-1:0] out_ReadData
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned REG_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Instruction captured at acceptance of a memory op, held across BUSY.
  typedef struct packed {
    logic              rd;
    logic              wr;
    logic              mtr;
    logic              rw;
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] sd;
  } req_t;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  req_t               req_q, req_d;

  logic               valid_q, valid_d;
  logic               mtr_q, mtr_d;
  logic               rw_q, rw_d;
  logic [REG_W-1:0]   wreg_q, wreg_d;
  logic [DATA_W-1:0]  alu_q, alu_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;

  // Upper address bits are dropped so accesses wrap around the memory.
  assign mem_addr = req_q.alu[ADDR_W-1:0];

  // Stall is a pure state decode; nothing from the inputs reaches it.
  assign out_stall = (state_q == BUSY);

  assign out_valid     = valid_q;
  assign out_MemtoReg  = mtr_q;
  assign out_RegWrite  = rw_q;
  assign out_WriteReg  = wreg_q;
  assign out_ALUResult = alu_q;
  assign out_ReadData  = rdata_q;

  // Next-state, latched request and MEM/WB register computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    valid_d = valid_q;
    mtr_d   = mtr_q;
    rw_d    = rw_q;
    wreg_d  = wreg_q;
    alu_d   = alu_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_MemRead || in_MemWrite) begin
            req_d.rd   = in_MemRead;
            req_d.wr   = in_MemWrite;
            req_d.mtr  = in_MemtoReg;
            req_d.rw   = in_RegWrite;
            req_d.wreg = in_WriteReg;
            req_d.alu  = in_ALUResult;
            req_d.sd   = in_StoreData;
            cnt_d      = CNT_W'(MEM_LAT - 1);
            state_d    = BUSY;
            valid_d    = 1'b0;
            rw_d       = 1'b0;
          end else begin
            valid_d = 1'b1;
            mtr_d   = in_MemtoReg;
            rw_d    = in_RegWrite;
            wreg_d  = in_WriteReg;
            alu_d   = in_ALUResult;
            rdata_d = '0;
          end
        end else begin
          valid_d = 1'b0;
          rw_d    = 1'b0;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
          valid_d = 1'b1;
          mtr_d   = req_q.mtr;
          rw_d    = req_q.rw;
          wreg_d  = req_q.wreg;
          alu_d   = req_q.alu;
          if (req_q.wr) begin
            // Store wins; a simultaneous read returns the stored word.
            mem_we  = 1'b1;
            rdata_d = req_q.rd ? req_q.sd : '0;
          end else begin
            rdata_d = mem_q[mem_addr];
          end
        end
      end
    endcase
  end

  // State, counter, latched request and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      valid_q <= 1'b0;
      mtr_q   <= 1'b0;
      rw_q    <= 1'b0;
      wreg_q  <= '0;
      alu_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      mtr_q   <= mtr_d;
      rw_q    <= rw_d;
      wreg_q  <= wreg_d;
      alu_q   <= alu_d;
      rdata_q <= rdata_d;
    end
  end

  // Data memory write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_addr] <= req_q.sd;
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed self-checking bench for memory_access_stage with MEM_LAT=2.
module tb_memory_access_stage;

  localparam int unsigned LAT = 2;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_MemRead;
  logic        in_MemWrite;
  logic        in_MemtoReg;
  logic        in_RegWrite;
  logic [2:0]  in_WriteReg;
  logic [15:0] in_ALUResult;
  logic [15:0] in_StoreData;
  logic        out_stall;
  logic        out_valid;
  logic        out_MemtoReg;
  logic        out_RegWrite;
  logic [2:0]  out_WriteReg;
  logic [15:0] out_ALUResult;
  logic [15:0] out_ReadData;

  int checks = 0;
  int errors = 0;

  memory_access_stage #(
    .DATA_W (16),
    .ADDR_W (8),
    .MEM_LAT(LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_MemRead   (in_MemRead),
    .in_MemWrite  (in_MemWrite),
    .in_MemtoReg  (in_MemtoReg),
    .in_RegWrite  (in_RegWrite),
    .in_WriteReg  (in_WriteReg),
    .in_ALUResult (in_ALUResult),
    .in_StoreData (in_StoreData),
    .out_stall    (out_stall),
    .out_valid    (out_valid),
    .out_MemtoReg (out_MemtoReg),
    .out_RegWrite (out_RegWrite),
    .out_WriteReg (out_WriteReg),
    .out_ALUResult(out_ALUResult),
    .out_ReadData (out_ReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic mtr,
                       input logic rw, input logic [2:0] wreg, input logic [15:0] alu,
                       input logic [15:0] sd);
    in_valid     = v;
    in_MemRead   = rd;
    in_MemWrite  = wr;
    in_MemtoReg  = mtr;
    in_RegWrite  = rw;
    in_WriteReg  = wreg;
    in_ALUResult = alu;
    in_StoreData = sd;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, 32'(out_stall), 32'h0);
    check({tag, "_valid"}, 32'(out_valid), 32'h0);
    check({tag, "_mtr"}, 32'(out_MemtoReg), 32'h0);
    check({tag, "_rw"}, 32'(out_RegWrite), 32'h0);
    check({tag, "_wreg"}, 32'(out_WriteReg), 32'h0);
    check({tag, "_alu"}, 32'(out_ALUResult), 32'h0);
    check({tag, "_rdata"}, 32'(out_ReadData), 32'h0);
  endtask

  // Issue one memory op, go idle, and step to the completion edge.
  task automatic mem_op(input string tag, input logic rd, input logic wr, input logic mtr,
                        input logic rw, input logic [2:0] wreg, input logic [15:0] alu,
                        input logic [15:0] sd);
    drive(1'b1, rd, wr, mtr, rw, wreg, alu, sd);
    tick();
    check({tag, "_stall0"}, 32'(out_stall), 32'h1);
    check({tag, "_bubble"}, 32'(out_valid), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    for (int i = 1; i < int'(LAT); i++) begin
      tick();
      check({tag, "_stallN"}, 32'(out_stall), 32'h1);
    end
    tick();
    check({tag, "_stall_end"}, 32'(out_stall), 32'h0);
    check({tag, "_valid"}, 32'(out_valid), 32'h1);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    #3;
    check_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;

    // Non-memory instruction
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 16'h1234, 16'h0);
    check("nm_stall_pre", 32'(out_stall), 32'h0);
    tick();
    check("nm_valid", 32'(out_valid), 32'h1);
    check("nm_alu", 32'(out_ALUResult), 32'h1234);
    check("nm_rdata", 32'(out_ReadData), 32'h0);
    check("nm_wreg", 32'(out_WriteReg), 32'h5);
    check("nm_rw", 32'(out_RegWrite), 32'h1);
    check("nm_stall", 32'(out_stall), 32'h0);

    // Idle cycle: valid and RegWrite clear, rest holds
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    tick();
    check("idle_valid", 32'(out_valid), 32'h0);
    check("idle_rw", 32'(out_RegWrite), 32'h0);
    check("idle_alu_hold", 32'(out_ALUResult), 32'h1234);
    check("idle_wreg_hold", 32'(out_WriteReg), 32'h5);

    // Store 0xBEEF to 0x10 with the dependent load held during the stall
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0010, 16'hBEEF);
    tick();
    check("st_stall_e0", 32'(out_stall), 32'h1);
    check("st_bubble", 32'(out_valid), 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 16'h0010, 16'h0);
    tick();
    check("st_stall_e1", 32'(out_stall), 32'h1);
    check("st_bubble1", 32'(out_valid), 32'h0);
    tick();
    check("st_done_stall", 32'(out_stall), 32'h0);
    check("st_done_valid", 32'(out_valid), 32'h1);
    check("st_rdata", 32'(out_ReadData), 32'h0);
    check("st_alu", 32'(out_ALUResult), 32'h0010);
    tick();
    check("ld_accept_stall", 32'(out_stall), 32'h1);
    check("ld_bubble", 32'(out_valid), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    tick();
    check("ld_stall_e1", 32'(out_stall), 32'h1);
    tick();
    check("ld_valid", 32'(out_valid), 32'h1);
    check("ld_rdata", 32'(out_ReadData), 32'hBEEF);
    check("ld_mtr", 32'(out_MemtoReg), 32'h1);
    check("ld_wreg", 32'(out_WriteReg), 32'h3);
    check("ld_rw", 32'(out_RegWrite), 32'h1);

    // Address wrap
    mem_op("wrap_st", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0105, 16'h00AA);
    check("wrap_st_rdata", 32'(out_ReadData), 32'h0);
    mem_op("wrap_ld", 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 16'h0005, 16'h0);
    check("wrap_ld_rdata", 32'(out_ReadData), 32'h00AA);
    check("wrap_ld_alu", 32'(out_ALUResult), 32'h0005);

    // Stall hold: inputs change every BUSY cycle and must be ignored
    mem_op("hold_init", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0030, 16'h1357);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 16'h0030, 16'h0);
    tick();
    check("hold_stall", 32'(out_stall), 32'h1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 16'h0030, 16'hFFFF);
    tick();
    check("hold_stall1", 32'(out_stall), 32'h1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 16'h4321, 16'h0);
    tick();
    check("hold_valid", 32'(out_valid), 32'h1);
    check("hold_rdata", 32'(out_ReadData), 32'h1357);
    check("hold_wreg", 32'(out_WriteReg), 32'h6);
    check("hold_alu", 32'(out_ALUResult), 32'h0030);
    check("hold_mtr", 32'(out_MemtoReg), 32'h1);
    tick();
    check("next_valid", 32'(out_valid), 32'h1);
    check("next_alu", 32'(out_ALUResult), 32'h4321);
    check("next_wreg", 32'(out_WriteReg), 32'h7);
    check("next_rdata", 32'(out_ReadData), 32'h0);
    check("next_stall", 32'(out_stall), 32'h0);
    mem_op("hold_verify", 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 16'h0030, 16'h0);
    check("hold_verify_rdata", 32'(out_ReadData), 32'h1357);

    // Simultaneous read and write: write-through
    mem_op("wt", 1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 16'h0040, 16'h2468);
    check("wt_rdata", 32'(out_ReadData), 32'h2468);
    mem_op("wt_ld", 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 16'h0040, 16'h0);
    check("wt_ld_rdata", 32'(out_ReadData), 32'h2468);

    // Reset mid-BUSY discards the pending store
    mem_op("rst_init", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0020, 16'h1111);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 16'h0020, 16'h5555);
    tick();
    check("rst_busy", 32'(out_stall), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    tick();
    rst_n = 1'b1;
    check_all_zero("postrst");
    mem_op("rst_ld", 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 16'h0020, 16'h0);
    check("rst_ld_rdata", 32'(out_ReadData), 32'h1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Memory-access stage of the 16-bit MIPS pipeline, placed between execute and write-back. It performs loads and stores against an internal word-addressed data memory with a programmable multi-cycle access latency and stalls upstream while an access is in flight. It registers the results into the MEM/WB pipeline outputs consumed by the write-back stage: `MemtoReg`, ALU result and read data.

## Interface
- `DATA_W`, 16, datapath and memory word width
- `ADDR_W`, 8, data-memory word-address width (2^ADDR_W words)
- `MEM_LAT`, 2, cycles per load/store access, legal range 1..15
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `in_valid` input 1: instruction presented by execute this cycle
- `in_MemRead` input 1: load
- `in_MemWrite` input 1: store
- `in_MemtoReg` input 1: write-back select, passed through
- `in_RegWrite` input 1: register-write enable, passed through
- `in_WriteReg` input 3: destination register, passed through
- `in_ALUResult` input DATA_W: address for memory ops, result otherwise
- `in_StoreData` input DATA_W: store data
- `out_stall` output 1: upstream must hold its outputs stable
- `out_valid` output 1: MEM/WB register holds a real instruction
- `out_MemtoReg` output 1, `out_RegWrite` output 1, `out_WriteReg` output 3: registered controls
- `out_ALUResult` output DATA_W, `out_ReadData` output DATA_W: registered data to write-back

## Operation
- FSM states: IDLE and BUSY, plus a 4-bit down-counter `cnt`.
- Memory address is `in_ALUResult[ADDR_W-1:0]`. Upper bits are ignored, so addresses wrap modulo 2^ADDR_W.
- IDLE, `in_valid`=1, no memory op: at the edge, load the MEM/WB register from the inputs, set `out_ReadData`=0 and `out_valid`=1. Stay in IDLE.
- IDLE, `in_valid`=0: at the edge, set `out_valid`=0 and `out_RegWrite`=0. Other outputs hold.
- IDLE, `in_valid`=1 with `in_MemRead` or `in_MemWrite`: at the edge, latch all inputs internally, set `cnt`=MEM_LAT-1, go to BUSY, and load a bubble (`out_valid`=0, `out_RegWrite`=0).
- BUSY, `cnt`≠0: decrement `cnt`. Outputs hold the bubble. All `in_*` are ignored.
- BUSY, `cnt`=0: at the edge, perform the access:
  - Store: write the latched data into memory at the latched address.
  - Load: `out_ReadData` = mem[addr].
  - Load the latched controls and `out_ALUResult`, set `out_valid`=1, return to IDLE.
- `in_MemRead` and `in_MemWrite` both set: the store is performed and `out_ReadData` = the stored data (write-through).
- Store: `out_ReadData`=0.
- Memory contents are not affected by reset and are undefined until written.
- Reset asserted mid-BUSY: the pending access is discarded (no memory write), the FSM goes to IDLE, and all outputs clear.

## Timing
- Reset values: `out_stall`=0, `out_valid`=0, `out_MemtoReg`=0, `out_RegWrite`=0, `out_WriteReg`=0, `out_ALUResult`=0, `out_ReadData`=0. FSM in IDLE, `cnt`=0.
- `out_stall` = (state==BUSY). It is decoded from state only, with no combinational path from `in_*`.
- Non-memory latency: 1 edge. The result is visible the cycle after acceptance.
- Memory-op latency: accepted at edge E0, result visible after edge E0+MEM_LAT. `out_stall` is high for exactly MEM_LAT cycles.
- Upstream advances at E0. The next instruction must be held stable while `out_stall`=1 and is sampled at the first IDLE edge.
- Back-to-back: a store to address A followed by a load from A returns the new data.
- MEM_LAT=1: BUSY lasts one cycle and the stall lasts one cycle.

## Test plan
- Reset: assert `rst_n`=0 mid-run → every output is 0 and `out_stall`=0 immediately, without waiting for a clock edge.
- Non-memory instruction: `in_valid`=1, `in_ALUResult`=0x1234, `in_RegWrite`=1, `in_WriteReg`=5 → next cycle `out_valid`=1, `out_ALUResult`=0x1234, `out_ReadData`=0, `out_WriteReg`=5. `out_stall` never rises.
- Store then load, MEM_LAT=2:
  - Store 0xBEEF to address 0x0010 → `out_stall` high for 2 cycles.
  - Then load from 0x0010 with `in_MemtoReg`=1 → `out_ReadData`=0xBEEF, `out_MemtoReg`=1, `out_valid`=1 two cycles after acceptance.
- Address wrap: store 0x00AA at `in_ALUResult`=0x0105, load from 0x0005 → `out_ReadData`=0x00AA.
- Stall hold: while BUSY, change `in_*` every cycle → the completed result reflects only the latched instruction. The instruction held after the stall is accepted on the first IDLE edge.
- Reset mid-BUSY: start a store of 0x5555 to 0x20 (word already 0x1111) and pulse `rst_n` low during BUSY → a later load of 0x20 returns 0x1111.
